// File: rtl/kwta_pkg.sv
// Shared types and helpers for the k-winner-take-all lateral-inhibition stage.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: tie-break mode enum, stage state enum, and pulse_width(WRES) = 2^WRES.
package kwta_pkg;

   typedef enum logic {
      TIE_LOWEST = 1'b0,
      TIE_ROTATE = 1'b1
   } tie_mode_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      SAT    = 2'd2
   } li_state_e;

   function automatic int pulse_width(input int wres);
      return 1 << wres;
   endfunction

endpackage

// File: rtl/li_pulse_gen.sv
// Per-neuron output shaper: a PW-cycle winner pulse plus an edge held until the wave ends.
// Latency: o_pulse/o_edge rise the cycle after i_grant is sampled.
// Backpressure: none; a grant is always accepted, and grst or rst clears the state at once.
// Ports: i_clk, i_rst (async, active high), i_grst (sync wave clear),
//        i_grant (one-cycle win), o_pulse (PW cycles wide), o_edge (held until grst).
module li_pulse_gen
   import kwta_pkg::*;
#(
   parameter int WRES = 3
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_grst,
   input  logic i_grant,
   output logic o_pulse,
   output logic o_edge
);

   localparam int CW = WRES + 1;
   localparam logic [CW-1:0] PW_CNT = CW'(pulse_width(WRES));

   logic [CW-1:0] r_cnt;
   logic          r_edge;

   // The top never grants a neuron twice in one wave, so reloading on
   // grant cannot retrigger a running pulse.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_edge <= 1'b0;
      end else if (i_grst) begin
         r_cnt  <= '0;
         r_edge <= 1'b0;
      end else if (i_grant) begin
         r_cnt  <= PW_CNT;
         r_edge <= 1'b1;
      end else if (r_cnt != '0) begin
         r_cnt  <= r_cnt - 1'b1;
      end
   end

   assign o_pulse = (r_cnt != '0);
   assign o_edge  = r_edge;

endmodule

// File: rtl/kwta_li_stage.sv
// k-WTA lateral inhibition: grants up to k winners per gamma wave among enabled, rising EC spikes.
// Latency: a spike edge sampled at cycle t shows on o_li_out/o_eout from t+1.
// Backpressure: none; surplus simultaneous edges are inhibited for the wave, edges are ignored once saturated.
// Ports: i_clk, i_rst (async, active high), i_grst (sync wave reset), i_ec_spikes[Q], i_neuron_en[Q],
//        i_k_sel[KW], i_tie_mode (0 lowest index, 1 rotating), o_li_out[Q] (PW-cycle pulses),
//        o_eout[Q] (held edges), o_win_count[KW], o_saturated.
module kwta_li_stage
   import kwta_pkg::*;
#(
   parameter int Q    = 4,
   parameter int WRES = 3,
   parameter int KW   = $clog2(Q + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_grst,
   input  logic [Q-1:0]  i_ec_spikes,
   input  logic [Q-1:0]  i_neuron_en,
   input  logic [KW-1:0] i_k_sel,
   input  logic          i_tie_mode,
   output logic [Q-1:0]  o_li_out,
   output logic [Q-1:0]  o_eout,
   output logic [KW-1:0] o_win_count,
   output logic          o_saturated
);

   localparam int PTRW = (Q > 1) ? $clog2(Q) : 1;
   localparam logic [KW-1:0] Q_K = KW'(Q);

   // ---------------- state ----------------
   logic [Q-1:0]    r_prev;
   logic [Q-1:0]    r_won;
   logic [Q-1:0]    r_inhibit;
   logic [KW-1:0]   r_win_count;
   logic [KW-1:0]   r_k_q;
   logic            r_saturated;
   tie_mode_e       r_tie_mode_q;
   li_state_e       r_state;
   logic [PTRW-1:0] r_rr_ptr;
   logic [PTRW-1:0] r_last_idx;

   // ---------------- combinational ----------------
   logic [Q-1:0]    w_rising;
   logic [Q-1:0]    w_cand;
   logic [Q-1:0]    w_grant;
   logic [KW-1:0]   w_remaining;
   logic [KW-1:0]   w_n_grant;
   logic [KW-1:0]   w_count_next;
   logic [KW-1:0]   w_k_new;
   logic [PTRW-1:0] w_start;
   logic [PTRW-1:0] w_last_idx;
   logic [PTRW-1:0] w_ptr_next;
   logic [PTRW-1:0] w_idx;
   logic            w_any_grant;
   int              w_sum;

   assign w_rising    = i_ec_spikes & ~r_prev;
   assign w_cand      = w_rising & i_neuron_en & ~r_won & ~r_inhibit;
   assign w_remaining = r_k_q - r_win_count;
   assign w_k_new     = (i_k_sel > Q_K) ? Q_K : i_k_sel;
   assign w_start     = (r_tie_mode_q == TIE_ROTATE) ? r_rr_ptr : '0;

   // Walk the Q channels in priority order (from w_start, wrapping) and grant
   // the first candidates until the remaining slots are used up. The last
   // granted index, in priority order, seeds the next wave's rotation.
   always_comb begin
      w_grant    = '0;
      w_n_grant  = '0;
      w_last_idx = r_last_idx;
      w_sum      = 0;
      w_idx      = '0;
      for (int j = 0; j < Q; j++) begin
         w_sum = int'(w_start) + j;
         w_idx = PTRW'((w_sum >= Q) ? (w_sum - Q) : w_sum);
         if ((r_state != SAT) && w_cand[w_idx] && (w_n_grant < w_remaining)) begin
            w_grant[w_idx] = 1'b1;
            w_n_grant      = w_n_grant + 1'b1;
            w_last_idx     = w_idx;
         end
      end
   end

   assign w_any_grant  = |w_grant;
   assign w_count_next = r_win_count + w_n_grant;
   assign w_ptr_next   = ((int'(r_last_idx) + 1) >= Q) ? '0 : (r_last_idx + 1'b1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prev       <= '0;
         r_won        <= '0;
         r_inhibit    <= '0;
         r_win_count  <= '0;
         r_k_q        <= '0;
         r_saturated  <= 1'b0;
         r_tie_mode_q <= TIE_LOWEST;
         r_state      <= IDLE;
         r_rr_ptr     <= '0;
         r_last_idx   <= '0;
      end else begin
         // Edge history keeps tracking even during grst so a spike held
         // across the wave boundary is not seen as a new edge afterwards.
         r_prev <= i_ec_spikes;
         if (i_grst) begin
            r_won        <= '0;
            r_inhibit    <= '0;
            r_win_count  <= '0;
            r_k_q        <= w_k_new;
            r_tie_mode_q <= tie_mode_e'(i_tie_mode);
            r_saturated  <= (w_k_new == '0);
            r_state      <= (w_k_new == '0) ? SAT : IDLE;
            // Rotation advances only past a rotating-mode wave that had winners.
            if ((r_tie_mode_q == TIE_ROTATE) && (r_win_count != '0))
               r_rr_ptr <= w_ptr_next;
         end else begin
            r_won <= r_won | w_grant;
            // Candidates that lost for lack of slots stay out for the whole wave.
            r_inhibit <= r_inhibit | (w_cand & ~w_grant);
            if (w_any_grant) begin
               r_win_count <= w_count_next;
               r_last_idx  <= w_last_idx;
               r_saturated <= (w_count_next == r_k_q);
               r_state     <= (w_count_next == r_k_q) ? SAT : ACTIVE;
            end
         end
      end
   end

   // ---------------- per-neuron output shaping ----------------
   for (genvar g = 0; g < Q; g++) begin : g_pulse
      li_pulse_gen #(
         .WRES (WRES)
      ) u_pulse (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_grst  (i_grst),
         .i_grant (w_grant[g]),
         .o_pulse (o_li_out[g]),
         .o_edge  (o_eout[g])
      );
   end

   assign o_win_count = r_win_count;
   assign o_saturated = r_saturated;

endmodule

// File: tb/tb_kwta_li_stage.sv
// Directed self-checking bench for kwta_li_stage (Q=4, WRES=3).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Ports of the DUT are all connected by name.
module tb_kwta_li_stage;

   logic       clk;
   logic       rst;
   logic       grst;
   logic [3:0] ec_spikes;
   logic [3:0] neuron_en;
   logic [2:0] k_sel;
   logic       tie_mode;
   logic [3:0] li_out;
   logic [3:0] eout;
   logic [2:0] win_count;
   logic       saturated;

   int n_checks = 0;
   int n_errors = 0;

   kwta_li_stage #(
      .Q    (4),
      .WRES (3)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_grst      (grst),
      .i_ec_spikes (ec_spikes),
      .i_neuron_en (neuron_en),
      .i_k_sel     (k_sel),
      .i_tie_mode  (tie_mode),
      .o_li_out    (li_out),
      .o_eout      (eout),
      .o_win_count (win_count),
      .o_saturated (saturated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle grst carrying the new k and tie mode.
   task automatic wave(input logic [2:0] k, input logic m);
      grst     = 1'b1;
      k_sel    = k;
      tie_mode = m;
      tick();
      grst = 1'b0;
   endtask

   // Present a spike pattern for exactly one sampling edge.
   task automatic spike(input logic [3:0] s);
      ec_spikes = s;
      tick();
      ec_spikes = '0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      grst      = 1'b0;
      ec_spikes = '0;
      neuron_en = 4'b1111;
      k_sel     = 3'd0;
      tie_mode  = 1'b0;
      #12;
      check("rst_li", li_out, 4'b0000);
      check("rst_eout", eout, 4'b0000);
      check("rst_wc", win_count, 3'd0);
      check("rst_sat", saturated, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("post_rst_sat", saturated, 1'b0);

      // ---- single winner baseline ----
      wave(3'd1, 1'b0);
      check("w1_sat_start", saturated, 1'b0);
      tick();
      tick();
      spike(4'b0100);
      check("base_li", li_out, 4'b0100);
      check("base_eout", eout, 4'b0100);
      check("base_wc", win_count, 3'd1);
      check("base_sat", saturated, 1'b1);
      repeat (7) tick();
      check("base_li_c8", li_out, 4'b0100);
      tick();
      check("base_li_end", li_out, 4'b0000);
      check("base_eout_held", eout, 4'b0100);
      spike(4'b0001);
      check("base_late_li", li_out, 4'b0000);
      check("base_late_eout", eout, 4'b0100);
      check("base_late_wc", win_count, 3'd1);

      // ---- tie, lowest-index mode ----
      wave(3'd1, 1'b0);
      spike(4'b1010);
      check("tie_k1_li", li_out, 4'b0010);
      check("tie_k1_wc", win_count, 3'd1);
      wave(3'd2, 1'b0);
      spike(4'b1010);
      check("tie_k2_li", li_out, 4'b1010);
      check("tie_k2_wc", win_count, 3'd2);
      check("tie_k2_sat", saturated, 1'b1);

      // ---- rotating priority ----
      wave(3'd1, 1'b1);
      spike(4'b0101);
      check("rot_w1_li", li_out, 4'b0001);
      wave(3'd1, 1'b1);
      spike(4'b0101);
      check("rot_w2_li", li_out, 4'b0100);
      wave(3'd1, 1'b1);
      spike(4'b0101);
      check("rot_w3_li", li_out, 4'b0001);

      // ---- mask and k=0 ----
      neuron_en = 4'b1011;
      wave(3'd4, 1'b0);
      spike(4'b0100);
      check("mask_li", li_out, 4'b0000);
      check("mask_wc", win_count, 3'd0);
      check("mask_sat", saturated, 1'b0);
      wave(3'd0, 1'b0);
      check("k0_sat_start", saturated, 1'b1);
      spike(4'b1111);
      check("k0_li", li_out, 4'b0000);
      check("k0_eout", eout, 4'b0000);
      check("k0_wc", win_count, 3'd0);
      check("k0_sat", saturated, 1'b1);
      neuron_en = 4'b1111;

      // ---- overflow inhibit, disable mid-wave ----
      wave(3'd2, 1'b0);
      spike(4'b0111);
      check("ovf_li", li_out, 4'b0011);
      check("ovf_wc", win_count, 3'd2);
      check("ovf_sat", saturated, 1'b1);
      neuron_en = 4'b0000;
      tick();
      check("dis_li", li_out, 4'b0011);
      check("dis_eout", eout, 4'b0011);
      neuron_en = 4'b1111;
      spike(4'b1000);
      check("ovf_late_li", li_out, 4'b0011);
      check("ovf_late_eout", eout, 4'b0011);
      check("ovf_late_wc", win_count, 3'd2);

      // ---- k_sel above Q clamps to Q ----
      wave(3'd7, 1'b0);
      spike(4'b1111);
      check("clamp_li", li_out, 4'b1111);
      check("clamp_wc", win_count, 3'd4);
      check("clamp_sat", saturated, 1'b1);

      // ---- grst mid-pulse, spike in grst cycle discarded ----
      wave(3'd1, 1'b0);
      spike(4'b0010);
      tick();
      tick();
      tick();
      check("grst_pre_li", li_out, 4'b0010);
      grst      = 1'b1;
      ec_spikes = 4'b0001;
      tick();
      grst = 1'b0;
      check("grst_li", li_out, 4'b0000);
      check("grst_eout", eout, 4'b0000);
      check("grst_wc", win_count, 3'd0);
      tick();
      check("grst_held_li", li_out, 4'b0000);
      check("grst_held_wc", win_count, 3'd0);
      ec_spikes = '0;

      // ---- rst mid-pulse clears outputs and rotation pointer ----
      wave(3'd1, 1'b1);
      spike(4'b0101);
      check("rst_pre_li", li_out, 4'b0100);
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_li", li_out, 4'b0000);
      check("arst_eout", eout, 4'b0000);
      check("arst_wc", win_count, 3'd0);
      check("arst_sat", saturated, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      wave(3'd1, 1'b1);
      spike(4'b0011);
      check("arst_rr_li", li_out, 4'b0001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
